// File: rtl/player_pkg.sv
// Shared types and sizing helpers for the music player controller.
// The PLAYER_FADE_EN build uses the FADE state; the default build never enters it.
package player_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSE  = 3'd2,
    S_SWITCH = 3'd3,
    S_FADE   = 3'd4
  } player_state_e;

  localparam int unsigned UNDERRUN_W = 8;

  // Width of a song index, never narrower than one bit.
  function automatic int unsigned SONG_IDX_W(input int unsigned num_songs);
    return (num_songs > 1) ? $clog2(num_songs) : 1;
  endfunction

endpackage

// File: rtl/player_vol_scale.sv
// Signed PCM sample times an unsigned gain, arithmetic-shifted down by the gain width.
// The product width leaves one spare bit, so the result never overflows SAMPLE_W.
module player_vol_scale #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOL_W    = 4
) (
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [VOL_W-1:0]    gain_i,
  output logic [SAMPLE_W-1:0] scaled_o
);

  localparam int unsigned PROD_W = SAMPLE_W + VOL_W + 1;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;

  // Sign-extend the sample, zero-extend the gain, multiply and scale back down.
  assign sample_ext = PROD_W'($signed(sample_i));
  assign gain_ext   = PROD_W'({1'b0, gain_i});
  assign prod       = sample_ext * gain_ext;
  assign scaled_o   = SAMPLE_W'(prod >>> VOL_W);

endmodule

// File: rtl/music_player_ctrl.sv
// Playback controller: song selection, play/pause, frame-paced sample fetch,
// digital volume and underrun counting. Define PLAYER_FADE_EN to fade out of PLAY.
module music_player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned NUM_SONGS    = 4,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned VOL_W        = 4,
  parameter int unsigned VOL_RESET    = 12,
  parameter int unsigned AUTO_ADVANCE = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_btn,
  input  logic                           next_btn,
  input  logic                           prev_btn,
  input  logic                           vol_up,
  input  logic                           vol_dn,
  input  logic                           new_frame,
  output logic                           sample_req,
  input  logic                           sample_valid,
  input  logic [SAMPLE_W-1:0]            sample_in,
  input  logic                           song_done,
  output logic [SONG_IDX_W(NUM_SONGS)-1:0] song_sel,
  output logic                           song_start,
  output logic [NUM_CH*SAMPLE_W-1:0]     pcm_out,
  output logic                           playing,
  output logic [UNDERRUN_W-1:0]          underrun_cnt
);

  localparam int unsigned IDX_W = SONG_IDX_W(NUM_SONGS);
  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_SONGS - 1);
  localparam logic [VOL_W-1:0] VOL_MAX  = '1;
  localparam logic [VOL_W-1:0] VOL_INIT = VOL_W'(VOL_RESET);

  player_state_e             state_q, state_d, target_q, target_d;
  player_state_e             act_state_c, act_target_c;
  logic [IDX_W-1:0]          song_sel_q, song_sel_d, act_sel_c, sel_next_c, sel_prev_c, sel_nav_c;
  logic                      act_c;
  logic [VOL_W-1:0]          vol_q, gain_c;
  logic [SAMPLE_W-1:0]       hold_q, scaled_c;
  logic [NUM_CH*SAMPLE_W-1:0] pcm_q;
  logic [UNDERRUN_W-1:0]     underrun_q;
  logic                      new_frame_q, pending_q, sample_req_q, song_start_q, playing_q;
  logic                      tick_c, nav_c, stream_c, vol_ok_c, pend_live_c;

`ifdef PLAYER_FADE_EN
  player_state_e             fade_state_q, fade_state_d, fade_target_q, fade_target_d;
  logic [IDX_W-1:0]          fade_sel_q, fade_sel_d;
  logic [VOL_W-1:0]          att_q, fade_gain_c;
  logic [2*VOL_W-1:0]        fade_prod_c;

  assign fade_prod_c = {VOL_W'(0), vol_q} * {VOL_W'(0), att_q};
  assign fade_gain_c = fade_prod_c[2*VOL_W-1:VOL_W];
  assign stream_c    = (state_q == S_PLAY) || ((state_q == S_FADE) && (att_q != '0));
  assign gain_c      = (state_q == S_FADE) ? fade_gain_c : vol_q;
`else
  assign stream_c    = (state_q == S_PLAY);
  assign gain_c      = vol_q;
`endif

  // Event decode: frame edge, single-direction navigation and wrapped song indices.
  assign tick_c      = new_frame & ~new_frame_q;
  assign nav_c       = next_btn ^ prev_btn;
  assign sel_next_c  = (song_sel_q == SEL_LAST) ? '0 : song_sel_q + IDX_W'(1);
  assign sel_prev_c  = (song_sel_q == '0) ? SEL_LAST : song_sel_q - IDX_W'(1);
  assign sel_nav_c   = next_btn ? sel_next_c : sel_prev_c;
  assign vol_ok_c    = (state_q != S_SWITCH) && (state_q != S_FADE);
  assign pend_live_c = pending_q & ~sample_valid;

  player_vol_scale #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_vol_scale (
    .sample_i (hold_q),
    .gain_i   (gain_c),
    .scaled_o (scaled_c)
  );

  // Next-state decode with song_done > next/prev > play_btn priority.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    song_sel_d   = song_sel_q;
    act_c        = 1'b0;
    act_state_c  = state_q;
    act_target_c = target_q;
    act_sel_c    = song_sel_q;
`ifdef PLAYER_FADE_EN
    fade_state_d  = fade_state_q;
    fade_target_d = fade_target_q;
    fade_sel_d    = fade_sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (nav_c) begin
          song_sel_d = sel_nav_c;
          target_d   = S_IDLE;
          state_d    = S_SWITCH;
        end else if (play_btn) begin
          target_d = S_PLAY;
          state_d  = S_SWITCH;
        end
      end
      S_PLAY: begin
        if (song_done) begin
          act_c = 1'b1;
          if (AUTO_ADVANCE != 0) begin
            act_state_c  = S_SWITCH;
            act_target_c = S_PLAY;
            act_sel_c    = sel_next_c;
          end else begin
            act_state_c = S_IDLE;
          end
        end else if (nav_c) begin
          act_c        = 1'b1;
          act_state_c  = S_SWITCH;
          act_target_c = S_PLAY;
          act_sel_c    = sel_nav_c;
        end else if (play_btn) begin
          act_c       = 1'b1;
          act_state_c = S_PAUSE;
        end
        if (act_c) begin
`ifdef PLAYER_FADE_EN
          state_d       = S_FADE;
          fade_state_d  = act_state_c;
          fade_target_d = act_target_c;
          fade_sel_d    = act_sel_c;
`else
          state_d    = act_state_c;
          target_d   = act_target_c;
          song_sel_d = act_sel_c;
`endif
        end
      end
      S_PAUSE: begin
        if (nav_c) begin
          song_sel_d = sel_nav_c;
          target_d   = S_PAUSE;
          state_d    = S_SWITCH;
        end else if (play_btn) begin
          state_d = S_PLAY;
        end
      end
      S_SWITCH: state_d = target_q;
`ifdef PLAYER_FADE_EN
      S_FADE: begin
        if (tick_c && (att_q == '0)) begin
          state_d    = fade_state_q;
          target_d   = fade_target_q;
          song_sel_d = fade_sel_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, volume, sample fetch, underrun counter and PCM output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= S_IDLE;
      song_sel_q   <= '0;
      vol_q        <= VOL_INIT;
      hold_q       <= '0;
      pending_q    <= 1'b0;
      pcm_q        <= '0;
      underrun_q   <= '0;
      new_frame_q  <= 1'b0;
      sample_req_q <= 1'b0;
      song_start_q <= 1'b0;
      playing_q    <= 1'b0;
`ifdef PLAYER_FADE_EN
      fade_state_q  <= S_IDLE;
      fade_target_q <= S_IDLE;
      fade_sel_q    <= '0;
      att_q         <= VOL_MAX;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      song_sel_q   <= song_sel_d;
      new_frame_q  <= new_frame;
      song_start_q <= (state_d == S_SWITCH);
      playing_q    <= (state_d == S_PLAY);
      sample_req_q <= 1'b0;

      if (vol_ok_c && vol_up && !vol_dn && (vol_q != VOL_MAX)) begin
        vol_q <= vol_q + VOL_W'(1);
      end else if (vol_ok_c && vol_dn && !vol_up && (vol_q != '0)) begin
        vol_q <= vol_q - VOL_W'(1);
      end

      if (sample_valid && pending_q) begin
        hold_q    <= sample_in;
        pending_q <= 1'b0;
      end

      if (tick_c) begin
        if (stream_c) begin
          pcm_q <= {NUM_CH{scaled_c}};
          if (!pend_live_c) begin
            sample_req_q <= 1'b1;
            pending_q    <= 1'b1;
          end else if (underrun_q != '1) begin
            underrun_q <= underrun_q + UNDERRUN_W'(1);
          end
        end else begin
          pcm_q <= '0;
        end
      end

      if (state_q == S_SWITCH) begin
        hold_q    <= '0;
        pending_q <= 1'b0;
      end

`ifdef PLAYER_FADE_EN
      fade_state_q  <= fade_state_d;
      fade_target_q <= fade_target_d;
      fade_sel_q    <= fade_sel_d;
      if ((state_q == S_FADE) && tick_c) begin
        att_q <= (att_q == '0) ? VOL_MAX : att_q - VOL_W'(1);
      end
`endif
    end
  end

  assign sample_req   = sample_req_q;
  assign song_start   = song_start_q;
  assign song_sel     = song_sel_q;
  assign pcm_out      = pcm_q;
  assign playing      = playing_q;
  assign underrun_cnt = underrun_q;

endmodule
